// File: rtl/uart_byte_tx.sv
// -----------------------------------------------------------------------------
// uart_byte_tx
// Serialises one byte per request onto an RS-232 style line:
//   start bit (0), 8 data bits LSB first, optional parity bit, 1 or 2 stop bits.
// Every bit period lasts CLK_DIV clock cycles.
//
// Parameters
//   CLK_DIV    : clk cycles per bit (2..65535)
//   PARITY_EN  : 1 = append a parity bit after the data bits
//   PARITY_ODD : 1 = odd parity, 0 = even (only used when PARITY_EN = 1)
//   STOP_BITS  : number of stop bits (1 or 2)
//
// Ports
//   clk        : system clock; all state changes on its rising edge
//   rst_n      : asynchronous active-low reset
//   comnd_en   : single-cycle byte send request
//   comnd_data : byte to send, sampled only when a request is accepted
//   tx_ready   : busy flag, high for the whole frame
//   rs232_tx   : serial line, idle high
//   tx_done    : one-cycle pulse in the cycle tx_ready falls
//   tx_overrun : one-cycle pulse after a request that arrived while busy
// -----------------------------------------------------------------------------
module uart_byte_tx #(
    parameter int unsigned CLK_DIV    = 434,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       comnd_en,
    input  logic [7:0] comnd_data,
    output logic       tx_ready,
    output logic       rs232_tx,
    output logic       tx_done,
    output logic       tx_overrun
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    localparam logic [15:0] BAUD_LAST  = 16'(CLK_DIV - 1);
    localparam logic [2:0]  STOP_LAST  = 3'(STOP_BITS - 1);
    localparam logic        USE_PARITY = (PARITY_EN != 0);
    localparam logic        ODD_PARITY = (PARITY_ODD != 0);

    // Parity of a byte, optionally inverted for odd parity.
    function automatic logic parity_f(input logic [7:0] byte_v, input logic odd_v);
        return (^byte_v) ^ odd_v;
    endfunction

    state_e      state_q;
    logic [15:0] baud_q;
    logic [2:0]  bit_q;      // data bit index in DATA, stop bit index in STOP
    logic [7:0]  data_q;
    logic        tx_q;
    logic        ready_q;
    logic        done_q;
    logic        ovr_q;

    logic        baud_last_d;
    logic [15:0] baud_inc_d;
    logic [2:0]  bit_inc_d;

    assign baud_last_d = (baud_q == BAUD_LAST);
    assign baud_inc_d  = baud_q + 16'd1;
    assign bit_inc_d   = bit_q + 3'd1;

    // Frame sequencer; every output is produced from the state being entered,
    // so the line and flags change in the same cycle as the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= 16'd0;
            bit_q   <= 3'd0;
            data_q  <= 8'd0;
            tx_q    <= 1'b1;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Any request while a frame is in flight (state != IDLE) is dropped.
            ovr_q  <= comnd_en & (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (comnd_en) begin
                        data_q  <= comnd_data;
                        bit_q   <= 3'd0;
                        baud_q  <= 16'd0;
                        state_q <= START;
                        tx_q    <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        tx_q    <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end
                START: begin
                    if (baud_last_d) begin
                        baud_q  <= 16'd0;
                        bit_q   <= 3'd0;
                        state_q <= DATA;
                        tx_q    <= data_q[0];
                    end else begin
                        baud_q  <= baud_inc_d;
                    end
                end
                DATA: begin
                    if (baud_last_d) begin
                        baud_q <= 16'd0;
                        if (bit_q == 3'd7) begin
                            bit_q <= 3'd0;
                            if (USE_PARITY) begin
                                state_q <= PARITY;
                                tx_q    <= parity_f(data_q, ODD_PARITY);
                            end else begin
                                state_q <= STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_q <= bit_inc_d;
                            tx_q  <= data_q[bit_inc_d];
                        end
                    end else begin
                        baud_q <= baud_inc_d;
                    end
                end
                PARITY: begin
                    if (baud_last_d) begin
                        baud_q  <= 16'd0;
                        bit_q   <= 3'd0;
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end else begin
                        baud_q  <= baud_inc_d;
                    end
                end
                STOP: begin
                    if (baud_last_d) begin
                        baud_q <= 16'd0;
                        if (bit_q == STOP_LAST) begin
                            bit_q   <= 3'd0;
                            state_q <= IDLE;
                            tx_q    <= 1'b1;
                            ready_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            bit_q <= bit_inc_d;
                        end
                    end else begin
                        baud_q <= baud_inc_d;
                    end
                end
                default: begin
                    // Corrupted state register: recover to a clean idle line.
                    state_q <= IDLE;
                    baud_q  <= 16'd0;
                    bit_q   <= 3'd0;
                    data_q  <= 8'd0;
                    tx_q    <= 1'b1;
                    ready_q <= 1'b0;
                    done_q  <= 1'b0;
                    ovr_q   <= 1'b0;
                end
            endcase
        end
    end

    assign tx_ready   = ready_q;
    assign rs232_tx   = tx_q;
    assign tx_done    = done_q;
    assign tx_overrun = ovr_q;

endmodule
